mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative-latency multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers; executes mult/multu/div/divu and the mthi/mtlo writes.
- Drives `busy`. The hazard unit combines `busy` with the E-stage `start` pulse to stall mult/div/mf/mt instructions sitting in D.
- HI/LO outputs feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, default 5: cycles `busy` stays high for mult/multu; legal range ≥1.
- DIV_CYCLES, default 10: cycles `busy` stays high for div/divu; legal range ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: a mult/multu/div/divu is in E this cycle.
- md_op  in  2  operation, valid with start: 00 mult, 01 multu, 10 div, 11 divu.
- hilo_we  in  1  mthi/mtlo is in E this cycle.
- hilo_sel  in  1  target of hilo_we: 0 = LO, 1 = HI.
- A  in  32  operand rs (forwarded E-stage value).
- B  in  32  operand rt (forwarded E-stage value).
- busy  out  1  operation in progress.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
Reset:
- While reset=0: busy=0, HI=0, LO=0, internal counter=0, pending-result registers=0.
- Assertion takes effect immediately, independent of clk.
- Reset mid-operation aborts the operation; no result is ever written.

States: IDLE, RUN.

IDLE:
- On an edge with start=1, latch A, B and md_op.
- Compute the 64-bit result into pending registers: {hi_p, lo_p}.
- Load counter with MULT_CYCLES (md_op[1]=0) or DIV_CYCLES (md_op[1]=1).
- Set busy=1 and enter RUN.

RUN:
- Each edge decrements the counter.
- On the edge where counter==1: HI<=hi_p, LO<=lo_p, busy<=0, enter IDLE.
- busy is therefore high for exactly N cycles after the start edge. New HI/LO are visible in the first cycle with busy=0.

Arithmetic:
- mult: signed 32×32→64; HI = upper 32 bits, LO = lower 32 bits.
- multu: same, unsigned.
- div: signed; LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- divu: unsigned quotient in LO, unsigned remainder in HI.
- B=0 for div/divu: the full DIV_CYCLES busy period still occurs; HI/LO remain unchanged at completion.

mthi/mtlo:
- In IDLE, an edge with hilo_we=1 and start=0 writes A to HI (hilo_sel=1) or to LO (hilo_sel=0).
- The write takes effect the same edge; busy stays 0.

Simultaneous and illegal events:
- start=1 and hilo_we=1 on the same IDLE edge: start is honoured, hilo_we is ignored.
- start or hilo_we asserted while busy=1: ignored. The hazard unit prevents this; the unit must still keep the in-flight operation intact.
- A start arriving on the same edge that busy falls is ignored, because the state is RUN at that edge. It may be accepted on the next edge.
- HI/LO never change during RUN until the completion edge.

Outputs: busy, HI and LO are registered. There is no combinational path from any input to any output.

Test Plan:
1. mult, A=0xFFFFFFFE, B=0x00000003, start pulse:
   - busy=1 for exactly 5 cycles.
   - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
   - HI/LO hold their old values throughout the busy period.
2. multu, same operands: after 5 busy cycles, HI=0x00000002, LO=0xFFFFFFFA.
3. div, A=0xFFFFFFF9 (−7), B=2:
   - busy for 10 cycles.
   - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - Repeat as divu: LO=0x7FFFFFFC, HI=0x00000001.
4. Preload HI=0x11111111 via mthi, then div with B=0: busy for 10 cycles; HI=0x11111111 and LO unchanged afterwards.
5. Start mult, then pulse mtlo A=0x5 and a second start (divu) at cycle 2 of busy:
   - Both are ignored.
   - busy drops after 5 cycles with the original mult result.
   - start+hilo_we on the same IDLE edge: only the operation executes.
6. Start div; drive reset=0 asynchronously mid-cycle at busy cycle 4:
   - busy, HI and LO go to 0 immediately.
   - After release, no late write occurs and busy stays 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative-latency multiply/divide unit for the MIPS E stage.
// Owns HI/LO and holds the result in pending registers until the busy period ends.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [31:0]        hi_p, hi_p_d, lo_p, lo_p_d;
  logic               wr_p, wr_p_d;
  logic               busy_d;
  logic [31:0]        hi_d, lo_d;

  logic [63:0]        result_c;
  logic               div_zero_c;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, divisor, quo, rem;

  // 64-bit result of the requested operation; divide by zero flagged instead of computed
  always_comb begin
    div_zero_c = (B == 32'd0);
    a_neg      = A[31] & ~md_op[0];
    b_neg      = B[31] & ~md_op[0];
    a_mag      = a_neg ? (~A + 32'd1) : A;
    b_mag      = b_neg ? (~B + 32'd1) : B;
    divisor    = div_zero_c ? 32'd1 : b_mag;
    quo        = a_mag / divisor;
    rem        = a_mag % divisor;
    if (a_neg ^ b_neg) quo = ~quo + 32'd1;
    if (a_neg)         rem = ~rem + 32'd1;
    case (md_op)
      2'b00:   result_c = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      2'b01:   result_c = {32'd0, A} * {32'd0, B};
      default: result_c = {rem, quo};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_p  <= '0;
      lo_p  <= '0;
      wr_p  <= 1'b0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      hi_p  <= hi_p_d;
      lo_p  <= lo_p_d;
      wr_p  <= wr_p_d;
      busy  <= busy_d;
      HI    <= hi_d;
      LO    <= lo_d;
    end
  end

  // Next-state: start wins over hilo_we in IDLE; all requests are dropped in RUN
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_p_d  = hi_p;
    lo_p_d  = lo_p;
    wr_p_d  = wr_p;
    busy_d  = busy;
    hi_d    = HI;
    lo_d    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          {hi_p_d, lo_p_d} = result_c;
          wr_p_d  = ~(md_op[1] & div_zero_c);
          cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          busy_d  = 1'b1;
          state_d = RUN;
        end else if (hilo_we) begin
          if (hilo_sel) hi_d = A;
          else          lo_d = A;
        end
      end
      RUN: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (wr_p) begin
            hi_d = hi_p;
            lo_d = lo_p;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .A(a), .B(b),
    .busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic we, input logic sel);
    start = 1'b1; md_op = op; a = av; b = bv; hilo_we = we; hilo_sel = sel;
    tick();
    start = 1'b0; hilo_we = 1'b0;
  endtask

  // Count remaining busy cycles while checking HI/LO hold, then check the result
  task automatic wait_busy(input string tag, input int exp_n, input logic [31:0] eh, input logic [31:0] el);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      check({tag, " hold_hi"}, hi, m_hi);
      check({tag, " hold_lo"}, lo, m_lo);
      tick();
      n++;
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(exp_n));
    m_hi = eh;
    m_lo = el;
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 2'b00; hilo_we = 1'b0; hilo_sel = 1'b0;
    a = 32'd0; b = 32'd0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // 1/2: mult and multu of -2 * 3
    start_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0);
    wait_busy("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    start_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0);
    wait_busy("multu", 5, 32'h00000002, 32'hFFFFFFFA);

    // 3: div/divu of 0xFFFFFFF9 by 2, plus signed overflow case
    start_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
    wait_busy("div", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    start_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
    wait_busy("divu", 10, 32'h00000001, 32'h7FFFFFFC);
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    wait_busy("div_ovf", 10, 32'h00000000, 32'h80000000);

    // 4: mthi then divide by zero leaves HI/LO untouched
    hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'h11111111;
    tick();
    hilo_we = 1'b0;
    m_hi = 32'h11111111;
    check("mthi hi", hi, m_hi);
    check("mthi busy", 32'(busy), 32'd0);
    check("mthi lo", lo, m_lo);
    start_op(2'b10, 32'h00000064, 32'h00000000, 1'b0, 1'b0);
    wait_busy("div0", 10, 32'h11111111, m_lo);

    // 5: mtlo and start during busy are ignored
    start_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0);
    check("inflight busy1", 32'(busy), 32'd1);
    tick();
    start = 1'b1; md_op = 2'b11; hilo_we = 1'b1; hilo_sel = 1'b0; a = 32'h00000005; b = 32'h00000001;
    tick();
    start = 1'b0; hilo_we = 1'b0;
    wait_busy("inflight", 3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    // start and mthi on the same IDLE edge: only the multiply happens
    start_op(2'b00, 32'h00000007, 32'h00000006, 1'b1, 1'b1);
    wait_busy("start_we", 5, 32'h00000000, 32'h0000002A);

    // 6: asynchronous reset mid-divide aborts it
    start_op(2'b10, 32'h00000064, 32'h00000007, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("pre_abort busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    tick(); tick();
    #2;
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("post_abort busy", 32'(busy), 32'd0);
      check("post_abort hi", hi, m_hi);
      check("post_abort lo", lo, m_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
